morph_frame_scheduler: RTL and testbench

//  Frame-level sequencer for the binary morphology chain (erode/dilate stages on the 1-bit mask path).

---
 rtl/morph_frame_scheduler.sv | 199 +++++++++++++++++++
 tb/tb_morph_frame_scheduler.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/morph_frame_scheduler.sv
// Frame-level sequencer for the binary morphology chain: shadow op commit at SOF,
// geometry checks, drain timing. Optional stats counters under MORPH_SCHED_STATS_EN.
module morph_frame_scheduler #(
    parameter int IMG_W     = 640,
    parameter int IMG_H     = 480,
    parameter int N_STAGE   = 4,
    parameter int DRAIN_CYC = 8,
    localparam int PW = $clog2(IMG_W + 1),
    localparam int LW = $clog2(IMG_H + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [2*N_STAGE-1:0] cfg_ops,
    input  logic                 cfg_enable,
    input  logic                 pre_frame_vsync,
    input  logic                 pre_frame_href,
    input  logic                 pre_frame_clken,
    output logic [2*N_STAGE-1:0] stage_sel,
    output logic [N_STAGE-1:0]   stage_en,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 err_geom,
    output logic                 err_overrun,
`ifdef MORPH_SCHED_STATS_EN
    output logic [15:0]          frame_cnt,
    output logic [7:0]           err_cnt,
`endif
    output logic [PW-1:0]        pix_cnt,
    output logic [LW-1:0]        line_cnt
);

    localparam int DW = $clog2(DRAIN_CYC + 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SOF,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic                 vs_d, hr_d;
    logic                 vs_rise, vs_fall, hr_fall;
    logic                 pending;
    logic [2*N_STAGE-1:0] shadow, active;
    logic [DW-1:0]        drain_q;
    logic                 accept, sof, commit;
    logic                 in_run, in_drain;
    logic                 geom_set, ovr_set;
    logic [LW:0]          line_eff;

    function automatic logic [2*N_STAGE-1:0] norm_ops(
        input logic [2*N_STAGE-1:0] ops
    );
        logic [2*N_STAGE-1:0] r;
        r = ops;
        for (int i = 0; i < N_STAGE; i++) begin
            if (ops[2*i +: 2] == 2'b11) r[2*i +: 2] = 2'b00;
        end
        return r;
    endfunction

    assign vs_rise  = pre_frame_vsync & ~vs_d;
    assign vs_fall  = ~pre_frame_vsync & vs_d;
    assign hr_fall  = ~pre_frame_href & hr_d;

    assign in_run   = (state_q == RUN);
    assign in_drain = (state_q == DRAIN);

    // Shadow is free exactly when nothing is waiting for a frame start.
    assign cfg_ready = ~pending;
    assign accept    = cfg_valid & cfg_ready;
    assign sof       = (state_q == WAIT_SOF) & cfg_enable & vs_rise;
    assign commit    = sof & pending;

    assign line_eff = {1'b0, line_cnt} + (LW + 1)'(hr_fall);
    assign geom_set = in_run &
                      ((hr_fall & (pix_cnt != PW'(IMG_W))) |
                       (vs_fall & (line_eff != (LW + 1)'(IMG_H))));
    assign ovr_set  = in_drain & vs_rise;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (cfg_enable) state_d = WAIT_SOF;
            end
            WAIT_SOF: begin
                if (!cfg_enable)  state_d = IDLE;
                else if (vs_rise) state_d = RUN;
            end
            RUN: begin
                if (vs_fall) state_d = DRAIN;
            end
            DRAIN: begin
                if (vs_rise || drain_q == DW'(1)) state_d = DONE;
            end
            DONE: begin
                state_d = cfg_enable ? WAIT_SOF : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // vs_d resets high so a vsync already high at release is not a rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vs_d    <= 1'b1;
            hr_d    <= 1'b0;
        end else begin
            state_q <= state_d;
            vs_d    <= pre_frame_vsync;
            hr_d    <= pre_frame_href;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
            shadow  <= '0;
            active  <= '0;
        end else begin
            if (accept) begin
                shadow  <= cfg_ops;
                pending <= 1'b1;
            end else if (commit) begin
                pending <= 1'b0;
            end
            if (commit) active <= norm_ops(shadow);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt  <= '0;
            line_cnt <= '0;
        end else if (sof) begin
            pix_cnt  <= '0;
            line_cnt <= '0;
        end else if (in_run) begin
            if (hr_fall)
                pix_cnt <= '0;
            else if (pre_frame_href && pre_frame_clken && pix_cnt != '1)
                pix_cnt <= pix_cnt + 1'b1;
            if (hr_fall && line_cnt != '1)
                line_cnt <= line_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_q <= '0;
        end else if (in_run && vs_fall) begin
            drain_q <= DW'(DRAIN_CYC);
        end else if (in_drain) begin
            drain_q <= drain_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_geom    <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            if (geom_set)    err_geom <= 1'b1;
            else if (accept) err_geom <= 1'b0;
            if (ovr_set)     err_overrun <= 1'b1;
            else if (accept) err_overrun <= 1'b0;
        end
    end

`ifdef MORPH_SCHED_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if (state_q == DONE) frame_cnt <= frame_cnt + 1'b1;
            if ((geom_set || ovr_set) && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 1'b1;
        end
    end
`endif

    assign stage_sel  = active;
    assign busy       = in_run | in_drain | (state_q == DONE);
    assign frame_done = (state_q == DONE);

    for (genvar i = 0; i < N_STAGE; i++) begin : g_en
        assign stage_en[i] = (in_run | in_drain) &
                             (active[2*i +: 2] != 2'b00);
    end

endmodule

// File: tb/tb_morph_frame_scheduler.sv
// Directed bench for morph_frame_scheduler on a small 8x4 frame.
module tb_morph_frame_scheduler;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int NS = 4;
    localparam int DC = 8;
    localparam int PW = $clog2(W + 1);
    localparam int LW = $clog2(H + 1);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cfg_valid = 1'b0;
    logic            cfg_enable = 1'b0;
    logic [2*NS-1:0] cfg_ops = '0;
    logic            vsync = 1'b0;
    logic            href = 1'b0;
    logic            clken = 1'b0;

    logic            cfg_ready;
    logic [2*NS-1:0] stage_sel;
    logic [NS-1:0]   stage_en;
    logic            busy, frame_done, err_geom, err_overrun;
    logic [PW-1:0]   pix_cnt;
    logic [LW-1:0]   line_cnt;
`ifdef MORPH_SCHED_STATS_EN
    logic [15:0]     frame_cnt;
    logic [7:0]      err_cnt;
`endif

    int total = 0;
    int bad = 0;

    morph_frame_scheduler #(
        .IMG_W(W), .IMG_H(H), .N_STAGE(NS), .DRAIN_CYC(DC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ops(cfg_ops),
        .cfg_enable(cfg_enable),
        .pre_frame_vsync(vsync),
        .pre_frame_href(href),
        .pre_frame_clken(clken),
        .stage_sel(stage_sel),
        .stage_en(stage_en),
        .busy(busy),
        .frame_done(frame_done),
        .err_geom(err_geom),
        .err_overrun(err_overrun),
`ifdef MORPH_SCHED_STATS_EN
        .frame_cnt(frame_cnt),
        .err_cnt(err_cnt),
`endif
        .pix_cnt(pix_cnt),
        .line_cnt(line_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [2*NS-1:0] ops);
        cfg_ops   = ops;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic sof();
        vsync = 1'b1;
        tick();
    endtask

    task automatic do_line(input int npix, input logic eg);
        href  = 1'b1;
        clken = 1'b1;
        repeat (npix) tick();
        href  = 1'b0;
        clken = 1'b0;
        tick();
        check("err_geom_line", err_geom, eg);
        tick();
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        vsync = 1'b0;
        while (n < 40) begin
            tick();
            n++;
            if (frame_done) break;
        end
        check(tag, n, DC + 1);
        tick();
        check("done_pulse", frame_done, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int seen;

        repeat (2) tick();
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_sel", stage_sel, 0);
        check("rst_en", stage_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        check("rst_errs", {err_geom, err_overrun}, 0);
        check("rst_cnts", {pix_cnt, line_cnt}, 0);
        rst_n = 1'b1;
        tick();

        // clean frame
        cfg_write(8'h66);
        check("t1_ready_lo", cfg_ready, 0);
        cfg_enable = 1'b1;
        tick();
        check("t1_wait_busy", busy, 0);
        check("t1_pre_sel", stage_sel, 0);
        sof();
        check("t1_sel", stage_sel, 8'h66);
        check("t1_en", stage_en, 4'hF);
        check("t1_ready_hi", cfg_ready, 1);
        check("t1_busy", busy, 1);
        for (int l = 0; l < H; l++) do_line(W, 1'b0);
        check("t1_lines", line_cnt, H);
        wait_done("t1_done_lat");
        check("t1_errs", {err_geom, err_overrun}, 0);
        check("t1_idle_busy", busy, 0);

        // mid-frame write is shadowed; last line ends with vsync
        cfg_write(8'h12);
        sof();
        check("t2_sel_a", stage_sel, 8'h12);
        check("t2_en_a", stage_en, 4'b0101);
        check("t2_ready", cfg_ready, 1);
        do_line(W, 1'b0);
        cfg_write(8'h39);
        check("t2_ready_lo", cfg_ready, 0);
        check("t2_sel_hold", stage_sel, 8'h12);
        do_line(W, 1'b0);
        do_line(W, 1'b0);
        href  = 1'b1;
        clken = 1'b1;
        repeat (W) tick();
        href  = 1'b0;
        clken = 1'b0;
        wait_done("t2_done_lat");
        check("t2_coincident_geom", err_geom, 0);
        check("t2_lines", line_cnt, H);

        // short line
        sof();
        check("t3_sel_b", stage_sel, 8'h09);
        check("t3_en_b", stage_en, 4'b0011);
        check("t3_ready", cfg_ready, 1);
        do_line(W, 1'b0);
        do_line(W - 1, 1'b1);
        do_line(W, 1'b1);
        do_line(W, 1'b1);
        wait_done("t3_done_lat");
        check("t3_geom_sticky", err_geom, 1);
        cfg_write(8'h66);
        check("t3_geom_clr", err_geom, 0);

        // overrun: vsync re-rises 3 cycles after fall
        sof();
        check("t4_sel", stage_sel, 8'h66);
        for (int l = 0; l < H; l++) do_line(W, 1'b0);
        vsync = 1'b0;
        repeat (3) tick();
        vsync = 1'b1;
        tick();
        check("t4_done", frame_done, 1);
        check("t4_ovr", err_overrun, 1);
        tick();
        check("t4_done_off", frame_done, 0);
        check("t4_skip_busy", busy, 0);
        repeat (5) tick();
        check("t4_skip_en", stage_en, 0);
        vsync = 1'b0;
        seen = 0;
        repeat (DC + 4) begin
            tick();
            if (frame_done) seen++;
        end
        check("t4_no_done", seen, 0);
        check("t4_ovr_sticky", err_overrun, 1);

        // all-bypass ops, enable dropped mid-frame
        cfg_write(8'hFF);
        check("t5_ovr_clr", err_overrun, 0);
        sof();
        check("t5_sel", stage_sel, 0);
        check("t5_en", stage_en, 0);
        check("t5_busy", busy, 1);
        do_line(W, 1'b0);
        cfg_enable = 1'b0;
        for (int l = 1; l < H; l++) do_line(W, 1'b0);
        wait_done("t5_done_lat");
        check("t5_idle", busy, 0);
        cfg_write(8'h55);
        check("t5_pend", cfg_ready, 0);
        sof();
        tick();
        check("t5_ignored", busy, 0);
        check("t5_pend_kept", cfg_ready, 0);
        check("t5_sel_kept", stage_sel, 0);

        // reset mid-line with vsync high
        cfg_enable = 1'b1;
        tick();
        vsync = 1'b0;
        tick();
        sof();
        check("t6_sel", stage_sel, 8'h55);
        check("t6_en", stage_en, 4'hF);
        href  = 1'b1;
        clken = 1'b1;
        repeat (3) tick();
        check("t6_pix", pix_cnt, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_sel", stage_sel, 0);
        check("t6_rst_en", stage_en, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_ready", cfg_ready, 1);
        check("t6_rst_pix", pix_cnt, 0);
        tick();
        rst_n = 1'b1;
        href  = 1'b0;
        clken = 1'b0;
        repeat (4) tick();
        check("t6_no_run", busy, 0);
        vsync = 1'b0;
        tick();
        sof();
        check("t6_run", busy, 1);
        check("t6_run_sel", stage_sel, 0);
        check("t6_run_en", stage_en, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
